// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing recovery. Samples an RGB stream with active-low
//   hsync/vsync, rebuilds pixel coordinates, validates the sync timing
//   against the configured mode and locks after LOCK_FRAMES clean frames.
//
// Ports
//   clk, rst_n         pixel clock (rising edge), async active-low reset
//   hsync, vsync       active-low syncs, sampled every clock
//   rgb[2:0]           pixel colour
//   pix_valid          x/y/rgb_out hold a visible pixel while locked
//   x[9:0], y[9:0]     recovered column / row
//   rgb_out[2:0]       sampled colour for (x,y)
//   frame_start        one-cycle pulse with valid pixel (0,0)
//   locked             decoder is in LOCKED
//   sync_err           one-cycle pulse on a timing violation
//   err_count[7:0]     saturating violation count
//
// Pipeline: stage 1 registers the sample and its counters/state; stage 2
// registers the outputs, so a sample reaches the outputs two edges later.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic       pix_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] rgb_out,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] LP_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] LP_H_SS   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] LP_H_SYNC = 10'(H_SYNC);
  localparam logic [9:0] LP_H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] LP_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] LP_V_SS   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] LP_V_SE   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] LP_V_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [7:0] LP_LOCK   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_hs_q, r_vs_q;
  logic [2:0] r_rgb_q;
  logic [9:0] r_hcnt, r_vcnt, r_hlow;
  logic       r_vf_line;
  logic [7:0] r_good, w_good_nxt;
  logic       r_err;

  logic       w_hfall, w_hrise, w_vfall, w_vrise;
  logic       w_hwrap, w_vwrap;
  logic [9:0] w_h_pred, w_v_pred;
  logic       w_err;

  logic       w_pix_valid_nxt, w_fs_nxt;
  logic [7:0] w_err_count_nxt;

  // Edge detect against the stage-1 copy; reset value 1 makes the first
  // low sample after reset a falling edge.
  assign w_hfall = r_hs_q & ~hsync;
  assign w_hrise = ~r_hs_q & hsync;
  assign w_vfall = r_vs_q & ~vsync;
  assign w_vrise = ~r_vs_q & vsync;

  // Free-running predictions for the current sample.
  assign w_h_pred = (r_hcnt == LP_H_LAST) ? '0 : r_hcnt + 10'd1;
  assign w_hwrap  = (r_hcnt == LP_H_LAST) & ~w_hfall;
  assign w_v_pred = w_hwrap ? ((r_vcnt == LP_V_LAST) ? '0 : r_vcnt + 10'd1) : r_vcnt;
  assign w_vwrap  = w_hwrap & (r_vcnt == LP_V_LAST) & ~w_vfall;

  // Violations are judged for the sample being captured this edge; hlow is
  // the length of the low run that ended just before an hrise sample.
  always_comb begin
    w_err = 1'b0;
    if (r_state != SEARCH) begin
      w_err = (w_hfall & (w_h_pred != LP_H_SS))                              // E1
            | ((w_h_pred == LP_H_SS) & hsync)                                // E2
            | (w_hrise & (r_hlow != LP_H_SYNC))                              // E3
            | (w_vfall & (w_v_pred != LP_V_SS))                              // E4
            | (w_hwrap & (r_vcnt == LP_V_SS) & ~w_vfall & ~r_vf_line)        // E5
            | (w_vrise & (w_v_pred != LP_V_SE));                             // E6
    end
  end

  // Input stage and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_q    <= 1'b1;
      r_vs_q    <= 1'b1;
      r_rgb_q   <= '0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hlow    <= '0;
      r_vf_line <= 1'b0;
    end else begin
      r_hs_q    <= hsync;
      r_vs_q    <= vsync;
      r_rgb_q   <= rgb;
      r_hcnt    <= w_hfall ? LP_H_SS : w_h_pred;
      r_vcnt    <= w_vfall ? LP_V_SS : w_v_pred;
      r_hlow    <= hsync ? '0 : ((r_hlow == '1) ? r_hlow : r_hlow + 10'd1);
      // Remembers a vfall within the current line for the E5 check.
      r_vf_line <= w_vfall ? 1'b1 : (w_hwrap ? 1'b0 : r_vf_line);
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_good  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_err   <= w_err;
    end
  end

  // FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    unique case (r_state)
      SEARCH: begin
        if (w_vfall) begin
          w_state_nxt = VERIFY;
          w_good_nxt  = '0;
        end
      end
      VERIFY: begin
        if (w_err) begin
          w_state_nxt = SEARCH;
        end else if (w_vwrap) begin
          w_good_nxt = r_good + 8'd1;
          if (r_good + 8'd1 >= LP_LOCK) w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_err) w_state_nxt = SEARCH;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // FSM: outputs. r_state already holds the decision made for the sample
  // that r_hcnt/r_vcnt/r_rgb_q describe.
  always_comb begin
    w_pix_valid_nxt = (r_state == LOCKED) & (r_hcnt < LP_H_ACT) & (r_vcnt < LP_V_ACT);
    w_fs_nxt        = w_pix_valid_nxt & (r_hcnt == '0) & (r_vcnt == '0);
    w_err_count_nxt = err_count;
    if (r_err && (err_count != '1)) w_err_count_nxt = err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      x           <= '0;
      y           <= '0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      pix_valid   <= w_pix_valid_nxt;
      x           <= r_hcnt;
      y           <= r_vcnt;
      rgb_out     <= r_rgb_q;
      frame_start <= w_fs_nxt;
      locked      <= (r_state == LOCKED);
      sync_err    <= r_err;
      err_count   <= w_err_count_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced 32x19 mode so whole frames fit
// in a short run. A bench-side generator produces the stream and remembers
// the position of each sample; outputs are judged against the position of
// the sample two edges back.
module tb_vga_sync_decoder;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1, vsync = 1'b1;
  logic [2:0] rgb = '0;
  logic       pix_valid, frame_start, locked, sync_err;
  logic [9:0] x, y;
  logic [2:0] rgb_out;
  logic [7:0] err_count;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .x(x), .y(y), .rgb_out(rgb_out),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Generator state and fault knobs.
  int gh, gv;
  bit short_arm = 0, drop_v = 0, prev_vs = 1;
  bit vf_seen = 0;
  int wraps = 0;
  int h0 = 0, v0 = 0, w0 = 0, h1 = 0, v1 = 0, w1 = 0;

  // Monitor results.
  int pixcnt = 0, pixbad = 0, fscnt = 0, fsbad = 0, errpulses = 0;
  int err_h = -1, err_v = -1, err_locked = -1;
  bit lock_seen = 0, prev_locked = 0;
  int lock_h = -1, lock_v = -1, lock_w = -1;

  task automatic step();
    bit hs, vs;
    hs = !(gh >= HA + HF && gh < HA + HF + HS);
    vs = !(gv >= VA + VF && gv < VA + VF + VS);
    if (short_arm && gv == 5 && gh == HA + HF + HS - 1) begin
      hs = 1'b1;
      short_arm = 0;
    end
    if (drop_v) vs = 1'b1;
    if (!vs && prev_vs) vf_seen = 1;
    prev_vs = vs;
    if (gh == 0 && gv == 0 && vf_seen) wraps++;
    hsync = hs;
    vsync = vs;
    rgb   = 3'(gh);
    h1 = h0; v1 = v0; w1 = w0;
    h0 = gh; v0 = gv; w0 = wraps;
    @(posedge clk);
    #1;
    if (pix_valid) begin
      pixcnt++;
      if (int'(x) != h1 || int'(y) != v1 || rgb_out != 3'(h1)) pixbad++;
    end
    if (frame_start) begin
      fscnt++;
      if (!pix_valid || h1 != 0 || v1 != 0) fsbad++;
    end
    if (sync_err) begin
      errpulses++;
      err_h = h1; err_v = v1; err_locked = locked;
    end
    if (locked && !prev_locked) begin
      lock_seen = 1;
      lock_h = h1; lock_v = v1; lock_w = w1;
    end
    prev_locked = locked;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) gv = 0;
    end
  endtask

  task automatic arm();
    vf_seen = 0; wraps = 0; lock_seen = 0;
    lock_h = -1; lock_v = -1; lock_w = -1;
  endtask

  task automatic run_until_lock(input string tag);
    for (int i = 0; i < 4 * FRAME && !lock_seen; i++) step();
    chk({tag, "_lock_seen"}, lock_seen, 1);
    chk({tag, "_lock_x"}, lock_h, 0);
    chk({tag, "_lock_y"}, lock_v, 0);
    chk({tag, "_lock_wraps"}, lock_w, 2);
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < FRAME + 10 && !(gh == h && gv == v); i++) step();
  endtask

  task automatic drive_raw(input bit hs, input bit vs);
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_rgb_out"}, rgb_out, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gh = int'($urandom_range(0, HT - 1));
    gv = int'($urandom_range(1, 10));
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Ideal stream: lock at the second (0,0) after the first vsync fall.
    arm();
    run_until_lock("ideal");
    for (int i = 0; i < 2 * FRAME - 1; i++) step();
    chk("ideal_pix_count", pixcnt, 2 * HA * VA);
    chk("ideal_pix_identity_bad", pixbad, 0);
    chk("ideal_frame_start_count", fscnt, 2);
    chk("ideal_frame_start_bad", fsbad, 0);
    chk("ideal_err_count", err_count, 0);
    chk("ideal_err_pulses", errpulses, 0);
    chk("ideal_locked", locked, 1);

    // Hsync pulse one clock short on line 5 -> E3 at the rise.
    short_arm = 1;
    run_to(0, 7);
    chk("short_err_pulses", errpulses, 1);
    chk("short_err_x", err_h, HA + HF + HS - 1);
    chk("short_err_y", err_v, 5);
    chk("short_err_locked", err_locked, 0);
    chk("short_err_count", err_count, 1);
    chk("short_locked", locked, 0);
    arm();
    run_until_lock("short_relock");
    chk("short_relock_err_pulses", errpulses, 1);

    // A frame with no vsync pulse -> E5 when the row steps to VA+VF+1.
    drop_v = 1;
    run_to(0, VA + VF + VS + 1);
    drop_v = 0;
    chk("drop_err_pulses", errpulses, 2);
    chk("drop_err_x", err_h, 0);
    chk("drop_err_y", err_v, VA + VF + 1);
    chk("drop_err_locked", err_locked, 0);
    chk("drop_err_count", err_count, 2);
    arm();
    run_until_lock("drop_relock");

    // Reset while the outputs show pixel (10,6).
    run_to(12, 6);
    chk("midrst_pre_x", x, 10);
    chk("midrst_pre_y", y, 6);
    chk("midrst_pre_rgb", rgb_out, 2);
    chk("midrst_pre_locked", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    arm();
    run_until_lock("midrst_relock");
    chk("midrst_err_count", err_count, 0);
    chk("midrst_pixbad", pixbad, 0);

    // Saturation: every vsync fall enters VERIFY and the following sample
    // produces a 1-clock hsync rise.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 254; i++) begin
      drive_raw(1'b0, 1'b0);
      drive_raw(1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) drive_raw(1'b1, 1'b1);
    chk("sat_err_count_254", err_count, 254);
    for (int i = 0; i < 46; i++) begin
      drive_raw(1'b0, 1'b0);
      drive_raw(1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) drive_raw(1'b1, 1'b1);
    chk("sat_err_count_255", err_count, 255);
    chk("sat_locked", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
